// File: rtl/gate_truth_sequencer_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_truth_sequencer_pkg;

  // Controller states; encodings are fixed so board-level debug can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Truth tables for common 2-input gates: bit i is the expected output for vector i.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

  // Width of a counter that must reach max_val (never narrower than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Command, result and gate-stimulus signals of the truth-table sequencer.
// slave is the sequencer itself; master is the host plus gate under test.
interface gate_truth_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            abort;
  logic [N_IN-1:0] gate_in;
  logic            gate_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    output start, abort, gate_out,
    input  gate_in, busy, done, pass, err_count, first_fail_vec
  );

  modport slave (
    input  start, abort, gate_out,
    output gate_in, busy, done, pass, err_count, first_fail_vec
  );
endinterface

// File: rtl/and_gate.sv
// Two-input AND gate used as the device under test on the bring-up board.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/gate_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled, flags the last dwell cycle and
// wraps to 0 so the next vector starts a fresh dwell window.
module gate_dwell_timer
  import gate_truth_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = cnt_width(DWELL - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Last-cycle flag comes straight off the count register.
  assign last = (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise advance and wrap after the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a small combinational gate through every input vector, holds each one
// for DWELL cycles, checks the sampled output against TRUTH and reports the
// mismatch count plus the first failing vector. All outputs are registered.
module gate_truth_sequencer
  import gate_truth_sequencer_pkg::*;
#(
  parameter int                     N_IN  = 2,
  parameter int                     DWELL = 4,
  parameter logic [(1<<N_IN)-1:0]   TRUTH = TT_AND2
) (
  input logic                    clk,
  input logic                    rst_n,
  gate_truth_sequencer_if.slave  bus
);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            timer_clr;
  logic            timer_en;
  logic            dwell_last;

  gate_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .last  (dwell_last)
  );

  // Next-state, vector counter and result bookkeeping.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        vec_d     = '0;
        busy_d    = 1'b0;
        timer_clr = 1'b1;
        if (bus.start && !bus.abort) begin
          state_d = ST_APPLY;
          busy_d  = 1'b1;
          err_d   = '0;
          ffv_d   = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (bus.abort) begin
          // Partial err_count/first_fail_vec stay visible for debug.
          state_d   = ST_IDLE;
          vec_d     = '0;
          busy_d    = 1'b0;
          pass_d    = 1'b0;
          timer_clr = 1'b1;
        end else begin
          timer_en = 1'b1;
          if (dwell_last) begin
            if (bus.gate_out != TRUTH[vec_q]) begin
              err_d = err_q + (N_IN+1)'(1);
              if (err_q == '0) begin
                ffv_d = vec_q;
              end else begin
                ffv_d = ffv_q;
              end
            end else begin
              err_d = err_q;
            end
            // Equality test on the last vector: the counter never wraps in a run.
            if (vec_q == VEC_LAST) begin
              state_d = ST_DONE;
              vec_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_d == '0);
            end else begin
              vec_d = vec_q + N_IN'(1);
            end
          end else begin
            vec_d = vec_q;
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        vec_d     = '0;
        busy_d    = 1'b0;
        timer_clr = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        vec_d     = '0;
        busy_d    = 1'b0;
        timer_clr = 1'b1;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
    end
  end

  assign bus.gate_in        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer driving the real and_gate, or a
// stuck-at-0 / stuck-at-1 gate output, with hand-computed expectations.
module tb_gate_truth_sequencer;
  import gate_truth_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic and_y;
  int   gate_mode;   // 0: real AND, 1: tied 0, 2: tied 1
  int   checks   = 0;
  int   failures = 0;

  logic [1:0] gi_log   [20];
  logic       done_log [20];
  logic       busy_log [20];
  logic [2:0] err0;
  logic       pass0;

  always #5 clk = ~clk;

  gate_truth_sequencer_if #(.N_IN(2)) bus ();

  and_gate u_gate (
    .a (bus.gate_in[1]),
    .b (bus.gate_in[0]),
    .y (and_y)
  );

  assign bus.gate_out = (gate_mode == 0) ? and_y : ((gate_mode == 1) ? 1'b0 : 1'b1);

  gate_truth_sequencer #(
    .N_IN  (2),
    .DWELL (4),
    .TRUTH (TT_AND2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then log 20 cycles; optionally re-pulse start at cycle repulse.
  task automatic do_run(input int repulse);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      gi_log[j]   = bus.gate_in;
      done_log[j] = bus.done;
      busy_log[j] = bus.busy;
      if (j == 0) begin
        err0  = bus.err_count;
        pass0 = bus.pass;
      end
      bus.start = (j == repulse);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; gate_mode = 0;
    #12;
    checks++;
    if ({bus.gate_in, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.gate_in, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec});
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_and_pass;
    logic [1:0] exp_gi;
    gate_mode = 0;
    do_run(-1);
    for (int j = 0; j < 20; j++) begin
      exp_gi = (j < 16) ? 2'(j / 4) : 2'd0;
      checks += 3;
      if (gi_log[j] !== exp_gi) begin
        failures++;
        $display("FAIL pass_gate_in cyc=%0d got=%0d exp=%0d", j, gi_log[j], exp_gi);
      end
      if (done_log[j] !== (j == 16)) begin
        failures++;
        $display("FAIL pass_done cyc=%0d got=%b exp=%b", j, done_log[j], (j == 16));
      end
      if (busy_log[j] !== (j < 16)) begin
        failures++;
        $display("FAIL pass_busy cyc=%0d got=%b exp=%b", j, busy_log[j], (j < 16));
      end
    end
    checks += 3;
    if (bus.pass !== 1'b1) begin failures++; $display("FAIL pass_flag got=%b exp=1", bus.pass); end
    if (bus.err_count !== 3'd0) begin failures++; $display("FAIL pass_err got=%0d exp=0", bus.err_count); end
    if (bus.first_fail_vec !== 2'd0) begin failures++; $display("FAIL pass_ffv got=%0d exp=0", bus.first_fail_vec); end
  endtask

  task automatic test_tied0;
    int pulses;
    gate_mode = 1;
    do_run(-1);
    pulses = 0;
    for (int j = 0; j < 20; j++) pulses += int'(done_log[j]);
    checks += 4;
    if (pulses != 1) begin failures++; $display("FAIL tied0_done_pulses got=%0d exp=1", pulses); end
    if (bus.err_count !== 3'd1) begin failures++; $display("FAIL tied0_err got=%0d exp=1", bus.err_count); end
    if (bus.first_fail_vec !== 2'd3) begin failures++; $display("FAIL tied0_ffv got=%0d exp=3", bus.first_fail_vec); end
    if (bus.pass !== 1'b0) begin failures++; $display("FAIL tied0_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_tied1;
    gate_mode = 2;
    do_run(-1);
    checks += 4;
    if (!done_log[16]) begin failures++; $display("FAIL tied1_done got=%b exp=1", done_log[16]); end
    if (bus.err_count !== 3'd3) begin failures++; $display("FAIL tied1_err got=%0d exp=3", bus.err_count); end
    if (bus.first_fail_vec !== 2'd0) begin failures++; $display("FAIL tied1_ffv got=%0d exp=0", bus.first_fail_vec); end
    if (bus.pass !== 1'b0) begin failures++; $display("FAIL tied1_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_gi;
    gate_mode = 0;
    // Previous run left err_count=3; start must clear it. Start re-pulsed in vector 2.
    do_run(9);
    checks += 2;
    if (err0 !== 3'd0) begin failures++; $display("FAIL b2b_err_cleared got=%0d exp=0", err0); end
    if (pass0 !== 1'b0) begin failures++; $display("FAIL b2b_pass_cleared got=%b exp=0", pass0); end
    for (int j = 0; j < 20; j++) begin
      exp_gi = (j < 16) ? 2'(j / 4) : 2'd0;
      checks += 2;
      if (gi_log[j] !== exp_gi) begin
        failures++;
        $display("FAIL b2b_gate_in cyc=%0d got=%0d exp=%0d", j, gi_log[j], exp_gi);
      end
      if (done_log[j] !== (j == 16)) begin
        failures++;
        $display("FAIL b2b_done cyc=%0d got=%b exp=%b", j, done_log[j], (j == 16));
      end
    end
    checks += 2;
    if (bus.pass !== 1'b1) begin failures++; $display("FAIL b2b_pass got=%b exp=1", bus.pass); end
    if (bus.err_count !== 3'd0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", bus.err_count); end
  endtask

  task automatic test_abort;
    int seen_done;
    int seen_busy;
    gate_mode = 2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    checks++;
    if (bus.gate_in !== 2'd2 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre gate_in=%0d busy=%b exp gate_in=2 busy=1", bus.gate_in, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks += 6;
    if (bus.gate_in !== 2'd0) begin failures++; $display("FAIL abort_gate_in got=%0d exp=0", bus.gate_in); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    if (bus.pass !== 1'b0) begin failures++; $display("FAIL abort_pass got=%b exp=0", bus.pass); end
    if (bus.err_count !== 3'd2) begin failures++; $display("FAIL abort_err got=%0d exp=2", bus.err_count); end
    if (bus.first_fail_vec !== 2'd0) begin failures++; $display("FAIL abort_ffv got=%0d exp=0", bus.first_fail_vec); end
    seen_done = 0;
    for (int j = 0; j < 20; j++) begin
      seen_done += int'(bus.done);
      tick();
    end
    checks++;
    if (seen_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    seen_busy = 0;
    for (int j = 0; j < 4; j++) begin
      seen_busy += int'(bus.busy);
      tick();
    end
    checks += 2;
    if (seen_busy != 0) begin failures++; $display("FAIL start_abort_busy got=%0d exp=0", seen_busy); end
    if (bus.err_count !== 3'd2) begin failures++; $display("FAIL start_abort_err got=%0d exp=2", bus.err_count); end
  endtask

  task automatic test_async_reset;
    gate_mode = 2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    checks++;
    if (bus.gate_in !== 2'd1 || bus.err_count !== 3'd1) begin
      failures++;
      $display("FAIL arst_pre gate_in=%0d err=%0d exp gate_in=1 err=1", bus.gate_in, bus.err_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gate_in, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec} !== 10'd0) begin
      failures++;
      $display("FAIL arst_outputs got=%b exp=0", {bus.gate_in, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec});
    end
    #2;
    rst_n = 1'b1;
    tick();
    gate_mode = 0;
    do_run(-1);
    checks += 5;
    if (gi_log[15] !== 2'd3) begin failures++; $display("FAIL arst_run_gate_in got=%0d exp=3", gi_log[15]); end
    if (done_log[16] !== 1'b1 || done_log[15] !== 1'b0) begin
      failures++;
      $display("FAIL arst_run_done got=%b%b exp=10", done_log[16], done_log[15]);
    end
    if (bus.pass !== 1'b1) begin failures++; $display("FAIL arst_run_pass got=%b exp=1", bus.pass); end
    if (bus.err_count !== 3'd0) begin failures++; $display("FAIL arst_run_err got=%0d exp=0", bus.err_count); end
    if (bus.first_fail_vec !== 2'd0) begin failures++; $display("FAIL arst_run_ffv got=%0d exp=0", bus.first_fail_vec); end
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_tied0();
    test_tied1();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
